// File: rtl/nn_pkg.sv
// nn_pkg: shared stream FSM states, Q6.10 data format constants and width helper.
package nn_pkg;
  typedef enum logic [1:0] {COLLECT, LEAD, STREAM, DONE} stream_state_t;
  localparam int DATA_INT_W = 6;
  localparam int DATA_FRAC_W = 10;
  function automatic int idxWidth(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/lane_capture_bank.sv
// lane_capture_bank: per-lane first-valid capture with flags and an indexed read port.
module lane_capture_bank import nn_pkg::*; #(
  parameter int numInputs = 32,
  parameter int dataWidth = 16,
  parameter int idxW = idxWidth(numInputs)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           enable,
  input  logic [numInputs*dataWidth-1:0] laneData,
  input  logic [numInputs-1:0]           laneValid,
  input  logic [idxW-1:0]                rdIdx,
  output logic                           allCaptured,
  output logic [dataWidth-1:0]           rdData
);
  logic [numInputs-1:0] flags, capNow;
  logic [dataWidth-1:0] dataR [numInputs];
  assign capNow = laneValid & ~flags & {numInputs{enable & ~clear}};
  // Counts lanes landing this cycle so the FSM can leave COLLECT on the same edge.
  assign allCaptured = &(flags | capNow);
  // Bypass lets element 0 stream on the capture edge when there is no lead.
  assign rdData = capNow[rdIdx] ? laneData[rdIdx*dataWidth +: dataWidth] : dataR[rdIdx];
  always_ff @(posedge clk)
    if (reset || clear) flags <= '0;
    else flags <= flags | capNow;
  always_ff @(posedge clk)
    for (int i = 0; i < numInputs; i++)
      if (capNow[i]) dataR[i] <= laneData[i*dataWidth +: dataWidth];
endmodule

// File: rtl/layer_stream_tx.sv
// layer_stream_tx: captures one inference from a neuron layer and replays it as a gap-free burst.
module layer_stream_tx import nn_pkg::*; #(
  parameter int numInputs = 32,
  parameter int dataWidth = 16,
  parameter int startLead = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [numInputs*dataWidth-1:0] laneData,
  input  logic [numInputs-1:0]           laneValid,
  input  logic                           clear,
  output logic                           streamStart,
  output logic [dataWidth-1:0]           streamData,
  output logic                           streamValid,
  output logic                           streamLast,
  output logic                           busy,
  output logic                           done
);
  localparam int idxW = idxWidth(numInputs);
  localparam logic [idxW-1:0] lastIdx = idxW'(numInputs - 1);
  localparam logic [1:0] leadEnd = 2'(startLead > 0 ? startLead - 1 : 0);
  localparam stream_state_t firstState = startLead > 0 ? LEAD : STREAM;
  stream_state_t state, stateNext;
  logic [idxW-1:0] idx, idxNext;
  logic [1:0] leadCnt, leadNext;
  logic allCaptured, startNext, validNext, lastNext;
  logic [dataWidth-1:0] rdData, dataNext;
  lane_capture_bank #(.numInputs(numInputs), .dataWidth(dataWidth), .idxW(idxW)) bank (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .enable(state == COLLECT),
    .laneData(laneData),
    .laneValid(laneValid),
    .rdIdx(idxNext),
    .allCaptured(allCaptured),
    .rdData(rdData)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= COLLECT;
      idx <= '0;
      leadCnt <= '0;
      streamStart <= 1'b0;
      streamValid <= 1'b0;
      streamLast <= 1'b0;
      streamData <= '0;
    end else begin
      state <= stateNext;
      idx <= idxNext;
      leadCnt <= leadNext;
      streamStart <= startNext;
      streamValid <= validNext;
      streamLast <= lastNext;
      streamData <= dataNext;
    end
  always_comb begin
    stateNext = clear ? COLLECT :
                state == COLLECT ? (allCaptured ? firstState : COLLECT) :
                state == LEAD ? (leadCnt == leadEnd ? STREAM : LEAD) :
                state == STREAM ? (idx == lastIdx ? DONE : STREAM) : DONE;
    leadNext = (state == LEAD && stateNext == LEAD) ? leadCnt + 2'd1 : 2'd0;
    idxNext = (state == STREAM && stateNext == STREAM) ? idx + 1'b1 : '0;
  end
  // Output registers load the values for the cycle the next state describes.
  always_comb begin
    startNext = stateNext == firstState && state != firstState;
    validNext = stateNext == STREAM;
    lastNext = validNext && idxNext == lastIdx;
    dataNext = validNext ? rdData : streamData;
  end
  assign busy = state == LEAD || state == STREAM;
  assign done = state == DONE;
endmodule

// File: tb/tb_layer_stream_tx.sv
// tb_layer_stream_tx: three lead variants driven in parallel against a timeline model and a neuron model.
module tb_layer_stream_tx;
  localparam int N = 4;
  localparam int W = 16;
  logic clk = 1'b0, reset = 1'b1, clear = 1'b0;
  logic [N*W-1:0] laneData = '0;
  logic [N-1:0] laneValid = '0;
  logic [2:0] st, vl, ls, bs, dn;
  logic [2:0][W-1:0] dat;
  int tests = 0, errors = 0, n = 0, allAt = -1;
  logic [N-1:0] got = '0;
  logic [W-1:0] capVal [N];
  logic rstPrev = 1'b0;
  int w [N];
  int bias;
  int acc [3];
  int k [3];
  always #5 clk = ~clk;

  layer_stream_tx #(.numInputs(N), .dataWidth(W), .startLead(0)) u0 (
    .clk(clk), .reset(reset), .laneData(laneData), .laneValid(laneValid), .clear(clear),
    .streamStart(st[0]), .streamData(dat[0]), .streamValid(vl[0]), .streamLast(ls[0]),
    .busy(bs[0]), .done(dn[0]));
  layer_stream_tx #(.numInputs(N), .dataWidth(W), .startLead(1)) u1 (
    .clk(clk), .reset(reset), .laneData(laneData), .laneValid(laneValid), .clear(clear),
    .streamStart(st[1]), .streamData(dat[1]), .streamValid(vl[1]), .streamLast(ls[1]),
    .busy(bs[1]), .done(dn[1]));
  layer_stream_tx #(.numInputs(N), .dataWidth(W), .startLead(3)) u3 (
    .clk(clk), .reset(reset), .laneData(laneData), .laneValid(laneValid), .clear(clear),
    .streamStart(st[2]), .streamData(dat[2]), .streamValid(vl[2]), .streamLast(ls[2]),
    .busy(bs[2]), .done(dn[2]));

  function automatic int leadOf(input int i);
    return i == 0 ? 0 : i == 1 ? 1 : 3;
  endfunction

  function automatic int golden();
    int s = bias;
    for (int j = 0; j < N; j++) s += int'($signed(capVal[j])) * w[j];
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", tag, obs, exp, n);
    end
  endtask

  // Timeline model: after the edge where the last lane lands, offset d counts edges;
  // start at d=0, element j at d=lead+j, done from d=lead+N onward.
  always @(posedge clk) begin
    n++;
    rstPrev = reset;
    if (reset || clear) begin
      got = '0;
      allAt = -1;
    end else if (allAt < 0) begin
      for (int j = 0; j < N; j++)
        if (laneValid[j] && !got[j]) begin
          got[j] = 1'b1;
          capVal[j] = laneData[j*W +: W];
        end
      if (&got) allAt = n;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      int d, L;
      L = leadOf(i);
      d = allAt < 0 ? -1 : n - allAt;
      check($sformatf("lead%0d start", L), 32'(st[i]), 32'(d == 0));
      check($sformatf("lead%0d valid", L), 32'(vl[i]), 32'(d >= L && d < L + N));
      check($sformatf("lead%0d last", L), 32'(ls[i]), 32'(d == L + N - 1));
      check($sformatf("lead%0d busy", L), 32'(bs[i]), 32'(d >= 0 && d < L + N));
      check($sformatf("lead%0d done", L), 32'(dn[i]), 32'(d >= L + N));
      if (d >= L && d < L + N) check($sformatf("lead%0d data", L), 32'(dat[i]), 32'(capVal[d-L]));
      else if (d >= L + N) check($sformatf("lead%0d hold", L), 32'(dat[i]), 32'(capVal[N-1]));
      else if (rstPrev) check($sformatf("lead%0d rstdata", L), 32'(dat[i]), 32'h0);
      if (st[i] === 1'b1) begin
        acc[i] = bias;
        k[i] = 0;
      end
      if (vl[i] === 1'b1 && k[i] < N) begin
        acc[i] += int'($signed(dat[i])) * w[k[i]];
        k[i]++;
      end
      if (ls[i] === 1'b1) check($sformatf("lead%0d neuron", L), acc[i], golden());
    end
  end

  task automatic drive(input logic [N-1:0] v, input logic [N*W-1:0] d);
    laneValid = v;
    laneData = d;
    @(negedge clk);
  endtask

  task automatic idle(input int c);
    laneValid = '0;
    repeat (c) @(negedge clk);
  endtask

  task automatic pulseClear();
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
  endtask

  initial begin
    for (int j = 0; j < N; j++) w[j] = int'($urandom_range(0, 1023)) - 512;
    bias = int'($urandom_range(0, 65535)) - 32768;
    for (int i = 0; i < 3; i++) begin
      acc[i] = 0;
      k[i] = N;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    drive(4'hF, {16'h0000, 16'h0200, 16'hFC00, 16'h0400});
    idle(10);
    pulseClear();
    for (int c = 0; c < 12; c++)
      drive({c == 0, c == 5, c == 9, c >= 2}, {$urandom, $urandom});
    idle(10);
    pulseClear();
    drive(4'hF, {$urandom, $urandom});
    idle(2);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    drive(4'hF, {16'h4444, 16'h3333, 16'h2222, 16'h1111});
    idle(10);
    pulseClear();
    drive(4'hF, {$urandom, $urandom});
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(8);
    drive(4'hF, {$urandom, $urandom});
    idle(10);
    pulseClear();
    clear = 1'b1;
    drive(4'hF, {$urandom, $urandom});
    clear = 1'b0;
    idle(3);
    drive(4'hF, {$urandom, $urandom});
    idle(10);
    for (int c = 0; c < 300; c++) begin
      clear = $urandom_range(0, 29) == 0;
      reset = $urandom_range(0, 79) == 0;
      drive(4'($urandom) & 4'($urandom), {$urandom, $urandom});
    end
    clear = 1'b0;
    reset = 1'b0;
    idle(12);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
